// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator with sub-word extract and RMW stores
//   ports: clk, rst_n (async active-low);
//          req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata (request);
//          rsp_valid/rsp_ready/rsp_rdata/rsp_err (response);
//          mem_we/mem_addr/mem_wd/mem_rd (word-addressed memory, combinational read)
module lsu_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0]  state;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, wdata_r, word_r;
  logic        err;
  logic [4:0]  sh;
  logic [31:0] mask, rd_sh, ext;
  always_comb begin
    err = (req_we ? (req_funct3[2] | &req_funct3[1:0])
                  : (&req_funct3[1:0] | &req_funct3[2:1]))
        | (req_funct3[1:0] == 2'b01 & req_addr[0])
        | (req_funct3[1:0] == 2'b10 & |req_addr[1:0])
        | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    // lane shift is byte*8; for aligned halves this equals half*16, for words 0
    sh    = {addr_r[1:0], 3'b000};
    mask  = f3_r[1:0] == 2'b00 ? 32'h0000_00ff << sh :
            f3_r[1:0] == 2'b01 ? 32'h0000_ffff << sh : '1;
    rd_sh = mem_rd >> sh;
    ext   = f3_r[1:0] == 2'b00 ? {{24{rd_sh[7] & ~f3_r[2]}}, rd_sh[7:0]} :
            f3_r[1:0] == 2'b01 ? {{16{rd_sh[15] & ~f3_r[2]}}, rd_sh[15:0]} : mem_rd;
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    mem_we    = state == WRITE;
    mem_addr  = (state == READ || state == WRITE) ? {addr_r[31:2], 2'b00} : '0;
    // full-word stores use an all-ones mask, so the captured word drops out
    mem_wd    = mem_we ? (word_r & ~mask) | ((wdata_r << sh) & mask) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_r      <= 1'b0;
      f3_r      <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      word_r    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_r      <= req_we;
          f3_r      <= req_funct3;
          addr_r    <= req_addr;
          wdata_r   <= req_wdata;
          rsp_err   <= err;
          rsp_rdata <= '0;
          state     <= err ? RESP : (req_we && req_funct3[1:0] == 2'b10) ? WRITE : READ;
        end
        READ: begin
          word_r <= mem_rd;
          if (!we_r) rsp_rdata <= ext;
          state  <= we_r ? WRITE : RESP;
        end
        WRITE: state <= RESP;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table-driven bench for lsu_ctrl with a behavioural memory
module tb_lsu_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [64];
  int errors = 0, checks = 0, wtotal = 0;
  lsu_ctrl #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) begin
    mem[mem_addr[7:2]] <= mem_wd;
    wtotal <= wtotal + 1;
  end
  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr, wdata;
    logic err; logic [31:0] rdata; int lat; int wcyc; logic [31:0] wd, ma;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask
  task automatic run(input vec_t v, input int idx);
    int k, wc, wcyc;
    logic [31:0] wdv;
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.we, v.f3, v.addr, v.wdata);
    rsp_ready = 1;
    chk({s, " req_ready"}, 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    chk({s, " mem_addr"}, mem_addr, v.ma);
    k = 1; wc = 0; wcyc = 0; wdv = 0;
    while (k < 8 && !rsp_valid) begin
      if (mem_we) begin wc++; wcyc = k; wdv = mem_wd; end
      @(negedge clk);
      k++;
    end
    chk({s, " latency"}, 32'(k), 32'(v.lat));
    chk({s, " rsp_err"}, 32'(rsp_err), 32'(v.err));
    chk({s, " rsp_rdata"}, rsp_rdata, v.rdata);
    chk({s, " write_cycle"}, 32'(wcyc), 32'(v.wcyc));
    chk({s, " write_count"}, 32'(wc), v.wcyc != 0 ? 1 : 0);
    chk({s, " mem_wd"}, wdv, v.wd);
    @(negedge clk);
    chk({s, " rsp_drop"}, 32'(rsp_valid), 0);
    chk({s, " ready_back"}, 32'(req_ready), 1);
  endtask
  initial begin
    logic [31:0] hold_d;
    int w0;
    vec_t lw;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    //          we  f3      addr          wdata         err rdata         lat wc wd            ma
    tbl[0]  = '{1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0,        2, 1, 32'hDEADBEEF, 32'h10};
    tbl[1]  = '{0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFFDE, 2, 0, 32'h0,        32'h10};
    tbl[2]  = '{0, 3'b100, 32'h13,  32'h0,        0, 32'h000000DE, 2, 0, 32'h0,        32'h10};
    tbl[3]  = '{0, 3'b001, 32'h12,  32'h0,        0, 32'hFFFFDEAD, 2, 0, 32'h0,        32'h10};
    tbl[4]  = '{0, 3'b101, 32'h10,  32'h0,        0, 32'h0000BEEF, 2, 0, 32'h0,        32'h10};
    tbl[5]  = '{1, 3'b000, 32'h11,  32'h12345677, 0, 32'h0,        3, 2, 32'hDEAD77EF, 32'h10};
    tbl[6]  = '{1, 3'b001, 32'h12,  32'hAAAA1234, 0, 32'h0,        3, 2, 32'h123477EF, 32'h10};
    tbl[7]  = '{0, 3'b010, 32'h10,  32'h0,        0, 32'h123477EF, 2, 0, 32'h0,        32'h10};
    tbl[8]  = '{0, 3'b010, 32'h12,  32'h0,        1, 32'h0,        1, 0, 32'h0,        32'h0};
    tbl[9]  = '{1, 3'b001, 32'h13,  32'h5555,     1, 32'h0,        1, 0, 32'h0,        32'h0};
    tbl[10] = '{1, 3'b010, 32'h100, 32'h5555,     1, 32'h0,        1, 0, 32'h0,        32'h0};
    tbl[11] = '{0, 3'b011, 32'h10,  32'h0,        1, 32'h0,        1, 0, 32'h0,        32'h0};
    tbl[12] = '{1, 3'b100, 32'h10,  32'h5555,     1, 32'h0,        1, 0, 32'h0,        32'h0};
    tbl[13] = '{1, 3'b000, 32'hFF,  32'h000000A5, 0, 32'h0,        3, 2, 32'hA5000000, 32'hFC};
    tbl[14] = '{0, 3'b000, 32'hFF,  32'h0,        0, 32'hFFFFFFA5, 2, 0, 32'h0,        32'hFC};
    tbl[15] = '{0, 3'b010, 32'hFC,  32'h0,        0, 32'hA5000000, 2, 0, 32'h0,        32'hFC};
    #2;
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wd", mem_wd, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", 32'(rsp_err), 0);
    @(negedge clk); rst_n = 1;
    chk("post_rst req_ready", 32'(req_ready), 1);
    for (int i = 0; i < 16; i++) run(tbl[i], i);
    // backpressure: hold response, second request must be ignored
    w0 = wtotal;
    @(negedge clk);
    drive(0, 3'b010, 32'h10, 0);
    rsp_ready = 0;
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    chk("bp rsp_valid", 32'(rsp_valid), 1);
    chk("bp rdata", rsp_rdata, 32'h123477EF);
    hold_d = rsp_rdata;
    drive(1, 3'b010, 32'h20, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp held valid", 32'(rsp_valid), 1);
      chk("bp held rdata", rsp_rdata, 32'h123477EF);
      chk("bp held err", 32'(rsp_err), 0);
      chk("bp req_ready", 32'(req_ready), 0);
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    chk("bp release valid", 32'(rsp_valid), 0);
    chk("bp release ready", 32'(req_ready), 1);
    @(negedge clk);
    chk("bp no second", 32'(rsp_valid), 0);
    chk("bp no write", 32'(wtotal - w0), 0);
    chk("bp mem untouched", mem[8], 0);
    // reset during READ of SB 0x10
    w0 = wtotal;
    @(negedge clk);
    drive(1, 3'b000, 32'h10, 32'h00000055);
    @(negedge clk); req_valid = 0;
    chk("rmw read addr", mem_addr, 32'h10);
    #1 rst_n = 0;
    #1;
    chk("mid rst mem_we", 32'(mem_we), 0);
    chk("mid rst mem_addr", mem_addr, 0);
    chk("mid rst mem_wd", mem_wd, 0);
    chk("mid rst rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no aborted rsp", 32'(rsp_valid), 0);
    end
    chk("rst no write", 32'(wtotal - w0), 0);
    lw = tbl[7];
    run(lw, 99);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator that sits between the core's execute stage and the word-addressed data memory (WE/A/WD/RD port, combinational read, write on posedge clk).
- Accepts one byte/halfword/word load or store request at a time via a valid/ready handshake.
- Loads: performs the word read, then extracts and sign- or zero-extends the addressed lane.
- Sub-word stores: performed as read-modify-write. Misaligned, out-of-range and illegal requests are rejected with rsp_err and never touch memory.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the attached memory; word index req_addr[31:2] >= MEM_WORDS is an error.

Ports:
clk  input  1  clock; all state updates on posedge clk
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data; lanes taken from LSBs
rsp_valid  output  1  response present; held until rsp_ready
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request rejected
mem_we  output  1  memory write enable
mem_addr  output  32  memory byte address, always word-aligned ({idx,2'b00})
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data, valid combinationally in the same cycle as mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - req_ready=1 once rst_n=1.
- State IDLE:
  - req_ready=1, mem_we=0, mem_addr=0.
  - On accept, latch we, funct3, addr, wdata.
  - Error checks, in order:
    - illegal code: stores with funct3 not in {000,001,010}; loads with funct3 in {011,110,111}.
    - halfword with addr[0]=1.
    - word with addr[1:0]!=0.
    - addr[31:2] >= MEM_WORDS.
  - Next state:
    - any error -> RESP, with err=1.
    - SW -> WRITE.
    - all loads, SB and SH -> READ.
- State READ:
  - mem_addr = aligned address, mem_we=0.
  - Capture mem_rd into the word register.
  - Load -> RESP, with rdata computed from the captured word.
    - byte lane = addr[1:0]; half lane = addr[1].
    - B/H sign-extend; BU/HU zero-extend.
  - Store -> WRITE.
- State WRITE:
  - mem_we=1 for exactly this cycle; mem_addr = aligned address.
  - mem_wd:
    - SW: wdata.
    - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
    - SH: captured word with half lane addr[1] replaced by wdata[15:0].
  - Next state -> RESP, with rdata=0, err=0.
- State RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable while held.
  - req_ready=0.
  - On rsp_ready -> IDLE; rsp_valid drops the next cycle.
- Latency, with accept at cycle T, rsp_valid first high at:
  - load: T+2.
  - SW: T+2.
  - SB/SH: T+3.
  - error: T+1.
- Memory write cycle: SW at T+1; SB/SH at T+2.
- Throughput: a new request can be accepted in the cycle after the response handshake (IDLE).
- Only one request is outstanding. req_valid outside IDLE is ignored and not latched.
- mem_we is asserted only in WRITE and never on an errored request.
- A store never reads-then-writes a different word.
- Reset mid-operation:
  - all outputs return to reset values immediately.
  - a pending RMW is abandoned; a memory word is either fully old or fully new, never partially merged.
  - no response is produced for the aborted request.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF:
  - T+1: mem_we=1, mem_addr=0x10, mem_wd=0xDEADBEEF.
  - T+2: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- After the SW above, loads (rsp at T+2, err=0):
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- SB 0x11, wdata 0x12345677:
  - T+1: mem_we=0, mem_addr=0x10.
  - T+2: mem_we=1, mem_wd=0xDEAD77EF.
  - T+3: rsp_valid.
  - Then SH 0x12, wdata 0xAAAA1234; then LW 0x10 -> 0x123477EF.
- Error requests: LW 0x12, SH 0x13, SW 0x100 (MEM_WORDS=64), load funct3=011.
  - each: rsp_err=1, rsp_rdata=0, rsp_valid at T+1.
  - mem_we never asserted.
- Backpressure: LW 0x10 with rsp_ready=0 for 3 cycles.
  - rsp_valid, rsp_rdata and rsp_err stable; req_ready=0.
  - a second req_valid in that window is not accepted.
  - on rsp_ready=1 -> IDLE the next cycle.
- Reset: assert rst_n=0 during READ of SB 0x10.
  - outputs go to reset values immediately; mem_we never pulses.
  - LW 0x10 after release returns the unchanged word.
